// File: rtl/present_share_encoder.sv
// present_share_encoder
// Splits an unmasked PRESENT state into first-order Boolean share pairs,
// one nibble at a time, each masked with a fresh random nibble.
// Only registered shares ever leave the block; the plain nibble stays internal.
module present_share_encoder #(
    parameter int N_NIB = 16,
    localparam int IW = (N_NIB > 1) ? $clog2(N_NIB) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*N_NIB-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         rnd,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    output logic [3:0]         a0,
    output logic [3:0]         a1,
    output logic [IW-1:0]      idx,
    output logic               last,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_NIB - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [4*N_NIB-1:0] blk;
    logic [3:0]         nibs [N_NIB];
    logic [3:0]         cur_nib;

    // Slice the captured block into nibbles and pick the one being encoded.
    always_comb begin
        for (int i = 0; i < N_NIB; i++) begin
            nibs[i] = blk[4*i +: 4];
        end
        cur_nib = nibs[idx];
    end

    // State register; reset abandons any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus handshake decode, taken from registered state only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        rnd_ready = 1'b0;
        out_valid = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                rnd_ready = 1'b1;
                if (rnd_valid) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                last      = (idx == LAST_IDX);
                if (out_ready) begin
                    state_nxt = (idx == LAST_IDX) ? IDLE : FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Block capture, share generation and zeroization after the final pair.
    // The secret block and shares are cleared on reset so nothing survives an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk <= '0;
            a0  <= '0;
            a1  <= '0;
            idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        blk <= in_data;
                        idx <= '0;
                    end
                end
                FETCH: begin
                    if (rnd_valid) begin
                        a0 <= cur_nib ^ rnd;
                        a1 <= rnd;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            blk <= '0;
                            a0  <= '0;
                            a1  <= '0;
                            idx <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
